// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed byte image into instruction memory.
// Little-endian word assembly. The core is held in reset until the image is complete.
module imem_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_rst
);

  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_words_done;
  logic [1:0]      r_idx;
  logic [23:0]     r_buf;
  logic [31:0]     r_waddr;
  logic [31:0]     r_wdata;
  logic            r_in_ready;
  logic            r_we;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            r_cpu_rst;

  logic            w_xfer;
  logic [CW-1:0]   w_count_full;
  logic            w_last_word;

  // Byte handshake, the full header count, and last-word detection
  assign w_xfer       = in_valid & r_in_ready;
  assign w_count_full = {in_data, r_count[7:0]};
  assign w_last_word  = ((r_words_done + CW'(1)) == r_count);

  // Loader FSM with registered outputs; each branch sets the outputs of the state it enters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_words_done <= '0;
      r_idx        <= '0;
      r_buf        <= '0;
      r_waddr      <= ADDR_BASE;
      r_wdata      <= '0;
      r_in_ready   <= 1'b0;
      r_we         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cpu_rst    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state      <= S_HDR0;
            r_words_done <= '0;
            r_waddr      <= ADDR_BASE;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_cpu_rst    <= 1'b1;
          end
        end
        S_HDR0: begin
          if (w_xfer) begin
            r_count[7:0] <= in_data;
            r_state      <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (w_xfer) begin
            r_count[15:8] <= in_data;
            if (w_count_full == '0) begin
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_cpu_rst  <= 1'b0;
            end else if (32'(w_count_full) > DEPTH) begin
              r_state    <= S_ERR;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_err      <= 1'b1;
            end else begin
              r_state    <= S_DATA;
              r_idx      <= '0;
            end
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
              2'd0: r_buf[7:0]   <= in_data;
              2'd1: r_buf[15:8]  <= in_data;
              2'd2: r_buf[23:16] <= in_data;
              default: begin
                // Whole word is published only with the write strobe
                r_wdata    <= {in_data, r_buf};
                r_state    <= S_WRITE;
                r_in_ready <= 1'b0;
                r_we       <= 1'b1;
              end
            endcase
          end
        end
        S_WRITE: begin
          r_we         <= 1'b0;
          r_words_done <= r_words_done + CW'(1);
          if (w_last_word) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b0;
          end else begin
            r_waddr    <= r_waddr + 32'd4;
            r_state    <= S_DATA;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_we       <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign we       = r_we;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign cpu_rst  = r_cpu_rst;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: a table of single-word loads plus hand-written multi-cycle sequences.
// A write scoreboard and a small instruction-memory model check every write.
module tb_imem_loader;

  localparam int unsigned DEPTH     = 256;
  localparam logic [31:0] ADDR_BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, we, busy, done, err, cpu_rst;
  logic [31:0] waddr, wdata;

  imem_loader #(.DEPTH(DEPTH), .ADDR_BASE(ADDR_BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .cpu_rst(cpu_rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          gap;
    logic [31:0] exp_word;
  } vec_t;

  exp_t        q[$];
  vec_t        vt[6];
  logic [31:0] tb_mem[DEPTH];
  logic [31:0] img[DEPTH];
  logic [31:0] last_waddr;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_we = 0;
  int          we_mark;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (we === 1'b1) begin
      n_we++;
      last_waddr = waddr;
      tb_mem[waddr[9:2]] = wdata;
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_we: got write %h @ %h, expected no write", wdata, waddr);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (waddr !== e.addr || wdata !== e.data) begin
          n_fail++;
          $display("FAIL sb_write: got %h @ %h, expected %h @ %h", wdata, waddr, e.data, e.addr);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Present one byte and hold it until the loader takes it
  task automatic send_byte(input logic [7:0] b);
    int cnt;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    cnt = 0;
    while (in_ready !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready=%b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      logic [31:0] t;
      t = w >> (8 * b);
      send_byte(t[7:0]);
    end
  endtask

  task automatic wait_end(input int limit);
    int c;
    c = 0;
    while (!(done === 1'b1 || err === 1'b1) && c < limit) begin
      @(negedge clk);
      c++;
    end
    if (c >= limit) begin
      n_checks++;
      n_fail++;
      $display("FAIL end_timeout: got done=%b err=%b, expected done or err", done, err);
    end
  endtask

  initial begin
    vt[0] = '{8'h13, 8'h00, 8'h00, 8'h00, 0, 32'h0000_0013};
    vt[1] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 1, 32'hDEAD_BEEF};
    vt[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 0, 32'h0000_0000};
    vt[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 2, 32'hFFFF_FFFF};
    vt[4] = '{8'h67, 8'h45, 8'h23, 8'h01, 1, 32'h0123_4567};
    vt[5] = '{8'h01, 8'h00, 8'h00, 8'h80, 3, 32'h8000_0001};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_waddr", waddr, ADDR_BASE);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_done_err_busy", {29'd0, done, err, busy}, 32'd0);
    rst = 1'b0;

    // Two-word program, then fetch through the memory model
    pulse_start();
    chk("hdr0_ready", {30'd0, in_ready, busy}, 32'd3);
    send_byte(8'h02); send_byte(8'h00);
    q.push_back('{ADDR_BASE, 32'h0000_0013});
    q.push_back('{ADDR_BASE + 32'd4, 32'h0010_0093});
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    @(negedge clk);
    chk("n2_we_last", 32'(we), 32'd1);
    @(negedge clk);
    chk("n2_done_cpu_rst", {30'd0, done, cpu_rst}, 32'd2);
    chk("fetch_pc0", tb_mem[0], 32'h0000_0013);
    chk("fetch_pc4", tb_mem[1], 32'h0010_0093);

    // Table: single-word loads, byte order and input gaps
    for (int i = 0; i < 6; i++) begin
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      q.push_back('{ADDR_BASE, vt[i].exp_word});
      send_byte(vt[i].b0); repeat (vt[i].gap) @(negedge clk);
      send_byte(vt[i].b1); repeat (vt[i].gap) @(negedge clk);
      send_byte(vt[i].b2); repeat (vt[i].gap) @(negedge clk);
      chk("partial_no_we", 32'(we), 32'd0);
      send_byte(vt[i].b3);
      @(negedge clk);
      chk("vec_we_latency", 32'(we), 32'd1);
      @(negedge clk);
      chk("vec_done_cpu_rst_ready", {29'd0, done, cpu_rst, in_ready}, 32'd4);
      chk("vec_wdata_hold", wdata, vt[i].exp_word);
      chk("vec_waddr", waddr, ADDR_BASE);
    end

    // N=0: straight to DONE, no write
    we_mark = n_we;
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    chk("n0_done_cpu_rst", {30'd0, done, cpu_rst}, 32'd2);
    chk("n0_no_we", 32'(n_we - we_mark), 32'd0);

    // N=257 exceeds depth
    pulse_start();
    send_byte(8'h01); send_byte(8'h01);
    @(negedge clk);
    chk("n257_err", {28'd0, err, done, in_ready, cpu_rst}, 32'd9);
    repeat (3) @(negedge clk);
    chk("n257_no_we", 32'(n_we - we_mark), 32'd0);

    // N=256 from ERR: fills the memory, last address is the top word
    for (int w = 0; w < int'(DEPTH); w++) img[w] = $urandom;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    for (int w = 0; w < int'(DEPTH); w++) begin
      q.push_back('{ADDR_BASE + 32'(4 * w), img[w]});
      send_word(img[w]);
    end
    wait_end(20);
    chk("n256_done", {30'd0, done, err}, 32'd2);
    chk("n256_last_waddr", last_waddr, ADDR_BASE + 32'h3FC);
    chk("n256_we_count", 32'(n_we - we_mark), 32'd256);
    chk("n256_mem_top", tb_mem[255], img[255]);

    // Start pulsed mid-load is ignored
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    q.push_back('{ADDR_BASE, 32'h1111_2222});
    q.push_back('{ADDR_BASE + 32'd4, 32'h3333_4444});
    send_byte(8'h22); send_byte(8'h22);
    pulse_start();
    chk("mid_start_busy", {30'd0, busy, in_ready}, 32'd3);
    send_byte(8'h11); send_byte(8'h11);
    send_word(32'h3333_4444);
    wait_end(10);
    chk("mid_start_done", 32'(done), 32'd1);
    chk("mid_start_mem1", tb_mem[1], 32'h3333_4444);

    // Start in DONE re-enters reset and overwrites word 0
    pulse_start();
    chk("restart_state", {29'd0, cpu_rst, done, busy}, 32'd5);
    send_byte(8'h01); send_byte(8'h00);
    q.push_back('{ADDR_BASE, 32'hCAFE_BABE});
    send_word(32'hCAFE_BABE);
    wait_end(10);
    chk("restart_mem0", tb_mem[0], 32'hCAFE_BABE);

    // Reset after half a word: no write, asynchronous return to reset values
    we_mark = n_we;
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_async", {29'd0, cpu_rst, in_ready, busy}, 32'd4);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_no_we", 32'(n_we - we_mark), 32'd0);
    chk("midrst_waddr", waddr, ADDR_BASE);
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    q.push_back('{ADDR_BASE, 32'h1234_5678});
    send_word(32'h1234_5678);
    wait_end(10);
    chk("midrst_reload", tb_mem[0], 32'h1234_5678);
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
